// File: rtl/lcd_pattern_sched.sv
// lcd_pattern_sched: frame-synchronous test-pattern scheduler and pixel source.
// Sits between rgb_timing and the panel pins. Four built-in patterns are
// rotated automatically every FRAMES_PER_PATTERN frames, or stepped on a
// handshaked manual request. Selection changes only at the falling edge of
// vsync, so a frame never tears. Pixels leave through a one-cycle register
// stage with sync and enable delayed to match.
`timescale 1ns/1ps
module lcd_pattern_sched #(
  parameter int unsigned H_ACTIVE           = 480,
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned PATTERN_NUM        = 4
) (
  input  logic        rgb_clk,
  input  logic        rgb_rst_n,
  input  logic        rgb_hs,
  input  logic        rgb_vs,
  input  logic        rgb_de,
  input  logic [9:0]  rgb_x,
  input  logic [9:0]  rgb_y,
  input  logic        auto_en,
  input  logic        step_req,
  output logic        step_ack,
  output logic [1:0]  pat_sel,
  output logic [7:0]  frame_cnt,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_rgb
);

  // Bar widths; clamped to 1 so a narrow panel never divides by zero.
  localparam int unsigned BIT_W = ((H_ACTIVE / 24) > 0) ? (H_ACTIVE / 24) : 1;
  localparam int unsigned BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [9:0]  BIT_W_L  = 10'(BIT_W);
  localparam logic [9:0]  BAR_W_L  = 10'(BAR_W);
  localparam logic [7:0]  FPP_LAST = 8'(FRAMES_PER_PATTERN - 1);
  localparam logic [1:0]  PAT_LAST = 2'(PATTERN_NUM - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_AUTO = 2'd1,
    S_PEND = 2'd2
  } state_t;

  // Wrapping advance; with a single pattern the index stays at 0.
  function automatic logic [1:0] next_pat(input logic [1:0] cur);
    logic [1:0] nxt;
    if (cur == PAT_LAST) begin
      nxt = 2'd0;
    end else begin
      nxt = cur + 2'd1;
    end
    return nxt;
  endfunction

  state_t      state_q;
  logic [1:0]  pat_sel_q;
  logic [7:0]  frame_cnt_q;
  logic        step_ack_q;
  logic        pend_q;
  logic        auto_s1_q;
  logic        auto_s2_q;
  logic        vs_d1_q;
  logic        req_d1_q;
  logic        out_hs_q;
  logic        out_vs_q;
  logic        out_de_q;
  logic [23:0] out_rgb_q;

  logic        auto_sync_s;
  logic        tick_s;
  logic        req_edge_s;
  logic [9:0]  bit_idx_s;
  logic [9:0]  bar_idx_s;
  logic [7:0]  gray_s;
  logic [23:0] pat_rgb_s;
  logic        unused_s;

  assign auto_sync_s = auto_s2_q;
  // Falling edge of active-low vsync: lies inside vertical blanking.
  assign tick_s      = vs_d1_q & ~rgb_vs;
  // Only a fresh rising edge counts; a held-high request never repeats.
  assign req_edge_s  = step_req & ~req_d1_q;
  // Only bit 4 of the row coordinate drives the checkerboard.
  assign unused_s    = ^{rgb_y[9:5], rgb_y[3:0]};

  // Two-flop synchronizer for the asynchronous auto_en level.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
    end else begin
      auto_s1_q <= auto_en;
      auto_s2_q <= auto_s1_q;
    end
  end

  // Previous-cycle copies of vsync and step_req for edge detection.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      vs_d1_q  <= 1'b1;
      req_d1_q <= 1'b0;
    end else begin
      vs_d1_q  <= rgb_vs;
      req_d1_q <= step_req;
    end
  end

  // Scheduler FSM: pending-step capture, frame counting and pattern advance.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      state_q     <= S_HOLD;
      pat_sel_q   <= 2'd0;
      frame_cnt_q <= 8'd0;
      step_ack_q  <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      step_ack_q <= 1'b0;
      // A new edge while a step is already pending merges into it.
      pend_q     <= pend_q | req_edge_s;
      case (state_q)
        S_AUTO: begin
          if (!auto_sync_s) begin
            state_q     <= S_HOLD;
            frame_cnt_q <= 8'd0;
          end else if (tick_s) begin
            // Expiry and a pending step on the same tick advance only once.
            if ((frame_cnt_q == FPP_LAST) || pend_q) begin
              pat_sel_q   <= next_pat(pat_sel_q);
              frame_cnt_q <= 8'd0;
              if (pend_q) begin
                step_ack_q <= 1'b1;
                pend_q     <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        S_HOLD: begin
          frame_cnt_q <= 8'd0;
          if (auto_sync_s) begin
            state_q <= S_AUTO;
          end else if (pend_q) begin
            state_q <= S_PEND;
          end
        end
        S_PEND: begin
          frame_cnt_q <= 8'd0;
          if (auto_sync_s) begin
            // The pending step is kept and served by the auto path.
            state_q <= S_AUTO;
          end else if (tick_s) begin
            pat_sel_q  <= next_pat(pat_sel_q);
            step_ack_q <= 1'b1;
            pend_q     <= 1'b0;
            state_q    <= S_HOLD;
          end
        end
        default: begin
          state_q     <= S_HOLD;
          frame_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  // Pattern generator for the current pixel coordinate and selection.
  always_comb begin
    bit_idx_s = rgb_x / BIT_W_L;
    bar_idx_s = rgb_x / BAR_W_L;
    gray_s    = rgb_x[8:1];
    pat_rgb_s = 24'h000000;
    case (pat_sel_q)
      2'd0: begin
        if (bit_idx_s < 10'd23) begin
          pat_rgb_s = 24'h800000 >> bit_idx_s;
        end else begin
          pat_rgb_s = 24'h000001;
        end
      end
      2'd1: begin
        case (bar_idx_s)
          10'd0:   pat_rgb_s = 24'hFFFFFF;
          10'd1:   pat_rgb_s = 24'hFFFF00;
          10'd2:   pat_rgb_s = 24'h00FFFF;
          10'd3:   pat_rgb_s = 24'h00FF00;
          10'd4:   pat_rgb_s = 24'hFF00FF;
          10'd5:   pat_rgb_s = 24'hFF0000;
          10'd6:   pat_rgb_s = 24'h0000FF;
          default: pat_rgb_s = 24'h000000;
        endcase
      end
      2'd2: begin
        pat_rgb_s = {gray_s, gray_s, gray_s};
      end
      2'd3: begin
        if (rgb_x[4] ^ rgb_y[4]) begin
          pat_rgb_s = 24'hFFFFFF;
        end else begin
          pat_rgb_s = 24'h000000;
        end
      end
      default: begin
        pat_rgb_s = 24'h000000;
      end
    endcase
  end

  // One-cycle output stage; pixel data blanked outside the active area.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      out_hs_q  <= 1'b1;
      out_vs_q  <= 1'b1;
      out_de_q  <= 1'b0;
      out_rgb_q <= 24'h000000;
    end else begin
      out_hs_q  <= rgb_hs;
      out_vs_q  <= rgb_vs;
      out_de_q  <= rgb_de;
      out_rgb_q <= rgb_de ? pat_rgb_s : 24'h000000;
    end
  end

  assign step_ack  = step_ack_q;
  assign pat_sel   = pat_sel_q;
  assign frame_cnt = frame_cnt_q;
  assign out_hs    = out_hs_q;
  assign out_vs    = out_vs_q;
  assign out_de    = out_de_q;
  assign out_rgb   = out_rgb_q;

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// Scoreboard bench for lcd_pattern_sched. A small timing generator drives a
// 3-line frame (two active lines at y=0 and y=16, one blanking line with
// vsync low). Expected pixel/sync values and expected scheduler events are
// queued by the stimulus side; two monitors pop and compare them.
`timescale 1ns/1ps
module tb_lcd_pattern_sched;

  logic        rgb_clk   = 1'b0;
  logic        rgb_rst_n = 1'b0;
  logic        rgb_hs, rgb_vs, rgb_de;
  logic [9:0]  rgb_x, rgb_y;
  logic        auto_en   = 1'b0;
  logic        step_req  = 1'b0;
  logic        step_ack;
  logic [1:0]  pat_sel;
  logic [7:0]  frame_cnt;
  logic        out_hs, out_vs, out_de;
  logic [23:0] out_rgb;

  int errors = 0;
  int checks = 0;

  lcd_pattern_sched #(
    .H_ACTIVE(480),
    .FRAMES_PER_PATTERN(3),
    .PATTERN_NUM(4)
  ) dut (
    .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n),
    .rgb_hs(rgb_hs), .rgb_vs(rgb_vs), .rgb_de(rgb_de),
    .rgb_x(rgb_x), .rgb_y(rgb_y),
    .auto_en(auto_en), .step_req(step_req), .step_ack(step_ack),
    .pat_sel(pat_sel), .frame_cnt(frame_cnt),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_rgb(out_rgb)
  );

  initial forever #5 rgb_clk = ~rgb_clk;

  // Hand-computed pixel vectors: pattern, x, y, expected colour.
  localparam int NV = 20;
  int vp [NV] = '{0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 1, 1,  2, 2, 2, 2,  3, 3, 3, 3};
  int vx [NV] = '{0, 20, 40, 459, 460, 479,  0, 60, 120, 359, 360, 420,
                  0, 255, 256, 479,  16, 16, 0, 0};
  int vy [NV] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 16, 16, 0};
  logic [23:0] vr [NV] = '{24'h800000, 24'h400000, 24'h200000, 24'h000002, 24'h000001, 24'h000001,
                           24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF0000, 24'h0000FF, 24'h000000,
                           24'h000000, 24'h7F7F7F, 24'h808080, 24'hEFEFEF,
                           24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};

  typedef struct {
    int          due;
    logic        hs, vs, de;
    logic [23:0] rgb;
    bit          chk;
  } pix_t;

  typedef struct {
    logic       ack;
    logic [1:0] pat;
    logic [7:0] cnt;
  } ev_t;

  pix_t pq[$];
  ev_t  evq[$];
  int   pos_cnt = 0;
  int   cur_ln  = 0;
  int   cur_hc  = 0;
  int   pix_pat = -1;
  event drv_ev;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial forever begin
    @(posedge rgb_clk);
    pos_cnt++;
  end

  // Timing generator; queues the expected registered copy of each cycle.
  initial begin
    int   hc, ln;
    pix_t e;
    hc = 0; ln = 0;
    rgb_hs = 1'b1; rgb_vs = 1'b1; rgb_de = 1'b0; rgb_x = 10'd0; rgb_y = 10'd0;
    forever begin
      @(posedge rgb_clk);
      #1;
      rgb_de = (ln < 2) && (hc < 480);
      rgb_x  = 10'(hc);
      rgb_y  = (ln == 1) ? 10'd16 : 10'd0;
      rgb_hs = !((hc >= 490) && (hc < 496));
      rgb_vs = !((ln == 2) && (hc < 100));
      cur_ln = ln;
      cur_hc = hc;
      if (rgb_rst_n) begin
        e.due = pos_cnt + 1;
        e.hs  = rgb_hs;
        e.vs  = rgb_vs;
        e.de  = rgb_de;
        e.rgb = 24'h000000;
        e.chk = !rgb_de;
        if (rgb_de) begin
          for (int i = 0; i < NV; i++) begin
            if (vp[i] == pix_pat && vx[i] == hc && vy[i] == int'(rgb_y)) begin
              e.chk = 1'b1;
              e.rgb = vr[i];
            end
          end
        end
        pq.push_back(e);
      end
      -> drv_ev;
      if (hc == 499) begin
        hc = 0;
        ln = (ln == 2) ? 0 : ln + 1;
      end else begin
        hc++;
      end
    end
  end

  // Pixel/sync monitor.
  initial begin
    pix_t e;
    forever begin
      @(negedge rgb_clk);
      if (!rgb_rst_n) begin
        pq.delete();
      end else begin
        while (pq.size() > 0 && pq[0].due < pos_cnt) begin
          e = pq.pop_front();
          checks++;
          errors++;
          $display("FAIL stale_pixel: entry due %0d, now %0d", e.due, pos_cnt);
        end
        if (pq.size() > 0 && pq[0].due == pos_cnt) begin
          e = pq.pop_front();
          check("sync_hs_vs_de", 32'({out_hs, out_vs, out_de}), 32'({e.hs, e.vs, e.de}));
          if (e.chk) begin
            check("pixel_rgb", 32'(out_rgb), 32'(e.rgb));
          end
        end
      end
    end
  end

  // Scheduler event monitor: any change of pat_sel/frame_cnt or an ack pulse.
  initial begin
    logic [9:0] prev;
    ev_t        e;
    prev = 10'd0;
    forever begin
      @(negedge rgb_clk);
      if (!rgb_rst_n) begin
        prev = {pat_sel, frame_cnt};
      end else if (({pat_sel, frame_cnt} != prev) || step_ack) begin
        prev = {pat_sel, frame_cnt};
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got ack=%0d pat=%0d cnt=%0d, required no change",
                   step_ack, pat_sel, frame_cnt);
        end else begin
          e = evq.pop_front();
          check("sched_event{ack,pat,cnt}", 32'({step_ack, pat_sel, frame_cnt}),
                32'({e.ack, e.pat, e.cnt}));
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(drv_ev);
  endtask

  task automatic wait_pos(int l, int h);
    do @(drv_ev); while (!(cur_ln == l && cur_hc == h));
  endtask

  task automatic wait_tick();
    wait_pos(2, 0);
  endtask

  task automatic push_ev(logic ack, logic [1:0] p, logic [7:0] c);
    ev_t e;
    e.ack = ack;
    e.pat = p;
    e.cnt = c;
    evq.push_back(e);
  endtask

  task automatic ev_drain(string tag);
    cycles(2);
    check({tag, "_events_outstanding"}, 32'(evq.size()), 32'd0);
    evq.delete();
  endtask

  task automatic pulse_step();
    wait_pos(0, 200);
    step_req = 1'b1;
    cycles(5);
    step_req = 1'b0;
  endtask

  task automatic step_once(logic [1:0] p);
    push_ev(1'b1, p, 8'd0);
    pulse_step();
    wait_tick();
    pix_pat = int'(p);
    wait_tick();
  endtask

  task automatic check_reset(string tag);
    check({tag, "_pat_sel"},   32'(pat_sel),   32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_step_ack"},  32'(step_ack),  32'd0);
    check({tag, "_out_sync"},  32'({out_hs, out_vs, out_de}), 32'b110);
    check({tag, "_out_rgb"},   32'(out_rgb),   32'd0);
  endtask

  // Directed stimulus sequence.
  initial begin
    cycles(4);
    check_reset("por");
    @(negedge rgb_clk);
    #2;
    pix_pat   = 0;
    rgb_rst_n = 1'b1;

    // Manual hold after reset: pattern 0 stays, bit-walk pixels checked.
    wait_tick(); wait_tick(); wait_tick();
    ev_drain("hold_idle");

    // Single manual steps through patterns 1, 2, 3.
    step_once(2'd1);
    step_once(2'd2);
    step_once(2'd3);
    ev_drain("manual_step");

    // Request held high across many frames gives exactly one advance.
    wait_pos(0, 200);
    push_ev(1'b1, 2'd0, 8'd0);
    step_req = 1'b1;
    wait_tick();
    pix_pat = 0;
    repeat (9) wait_tick();
    step_req = 1'b0;
    ev_drain("held_req");

    // Auto rotation with 3 frames per pattern.
    pix_pat = -1;
    wait_pos(0, 200);
    for (int i = 1; i <= 12; i++) begin
      push_ev(1'b0, 2'((i / 3) % 4), 8'(i % 3));
    end
    auto_en = 1'b1;
    repeat (12) wait_tick();
    ev_drain("auto_rotate");

    // Step coinciding with expiry, then a step without expiry.
    push_ev(1'b0, 2'd0, 8'd1);
    push_ev(1'b0, 2'd0, 8'd2);
    wait_tick(); wait_tick();
    push_ev(1'b1, 2'd1, 8'd0);
    pulse_step();
    wait_tick();
    push_ev(1'b0, 2'd1, 8'd1);
    wait_tick();
    push_ev(1'b1, 2'd2, 8'd0);
    pulse_step();
    wait_tick();
    push_ev(1'b0, 2'd2, 8'd1);
    wait_tick();
    ev_drain("auto_step");

    // Auto falling: frame count clears, pattern holds.
    wait_pos(0, 200);
    push_ev(1'b0, 2'd2, 8'd0);
    auto_en = 1'b0;
    wait_tick();
    pix_pat = 2;
    wait_tick(); wait_tick();
    ev_drain("auto_to_hold");

    // Reset while a step is pending: asynchronous clear, step discarded.
    wait_pos(0, 200);
    step_req = 1'b1;
    cycles(3);
    step_req = 1'b0;
    cycles(2);
    #2;
    rgb_rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    cycles(3);
    @(negedge rgb_clk);
    #2;
    pix_pat   = 0;
    rgb_rst_n = 1'b1;
    wait_tick(); wait_tick(); wait_tick();
    ev_drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #3ms;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lcd_pattern_sched.md
# lcd_pattern_sched

Frame-synchronous test-pattern scheduler and pixel source for the 480-pixel RGB LCD path. It sits between `rgb_timing` and the panel pins. It selects one of four built-in patterns, advances the selection automatically every N frames or on a handshaked manual step request, and applies changes only at the start of the vertical sync pulse. Pixel output is a one-cycle registered pipeline, with sync and enable delayed to match.

## Interface
- `H_ACTIVE`, default 480: active pixels per line; bar widths derive from it.
- `FRAMES_PER_PATTERN`, default 60: frames per pattern in auto mode; legal range 1..255.
- `PATTERN_NUM`, default 4: number of patterns in rotation; legal range 1..4; patterns ≥ `PATTERN_NUM` are never selected.
- `rgb_clk`  in  1  pixel clock; the only clock.
- `rgb_rst_n`  in  1  asynchronous active-low reset.
- `rgb_hs`, `rgb_vs`  in  1  timing sync from `rgb_timing`, active-low.
- `rgb_de`  in  1  data enable from `rgb_timing`.
- `rgb_x`, `rgb_y`  in  10  pixel coordinates, valid while `rgb_de`=1.
- `auto_en`  in  1  asynchronous level: 1 = timed rotation, 0 = manual hold.
- `step_req`  in  1  level request to advance one pattern.
- `step_ack`  out  1  one-cycle pulse: the requested step has been applied.
- `pat_sel`  out  2  current pattern index.
- `frame_cnt`  out  8  frames elapsed on the current pattern (auto mode).
- `out_hs`, `out_vs`, `out_de`  out  1  sync and enable, delayed 1 cycle.
- `out_rgb`  out  24  pixel data {R[7:0], G[7:0], B[7:0]}.

## Operation
- `auto_en` passes through a 2-flop synchronizer; only the synchronized value is used.
- `vs_d1` registers `rgb_vs`. Frame tick = `vs_d1 & ~rgb_vs`, a one-cycle pulse on the falling edge of vsync. This lies inside vertical blanking, so no frame tears.
- Step capture: a rising edge of `step_req` (req_d1=0, req=1) sets `pend`. A held-high `step_req` never produces a second request. A new edge while `pend`=1 is ignored (it merges).
- The FSM has three states:
  - `S_AUTO`, entered when auto is synchronized high. On each tick, `frame_cnt` increments. At tick with `frame_cnt` = `FRAMES_PER_PATTERN`-1, or with `pend`=1: `pat_sel` advances, `frame_cnt` clears, and if `pend` was set, `step_ack` pulses and `pend` clears. When auto expiry and a pending step coincide on the same tick, the pattern advances by exactly one.
  - `S_HOLD`, entered when auto is synchronized low and `pend`=0. `frame_cnt` is forced to 0 and `pat_sel` holds. `pend` rising moves to `S_PEND`.
  - `S_PEND`: at the next tick, `pat_sel` advances, `step_ack` pulses, `pend` clears, and the FSM returns to `S_HOLD`. If auto goes high, the FSM moves to `S_AUTO` with `pend` kept.
- Auto-to-hold transition: the FSM moves on the cycle the synchronized auto falls. `frame_cnt` clears on that cycle.
- Advance rule: `pat_sel` = (`pat_sel` = `PATTERN_NUM`-1) ? 0 : `pat_sel`+1. With `PATTERN_NUM`=1, `pat_sel` stays 0 but `step_ack` still pulses.
- Patterns, with W = `H_ACTIVE`/24 and B = `H_ACTIVE`/8 (integer division):
  - 0, bit walk: k = `rgb_x`/W, giving `rgb` = 24'h800000 >> k for k < 23, otherwise 24'h000001.
  - 1, colour bars: index `rgb_x`/B gives FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Indices ≥ 7 give 000000.
  - 2, gray ramp: g = `rgb_x`[8:1], giving `rgb` = {g,g,g}.
  - 3, checker: `rgb_x`[4]^`rgb_y`[4] ? FFFFFF : 000000.
- `out_rgb` = registered(`rgb_de` ? pattern : 24'h0). `out_hs`/`out_vs`/`out_de` are registered copies of the inputs.

## Timing
- Reset (async assert, sync-release use):
  - `pat_sel`=0, `frame_cnt`=0, `step_ack`=0.
  - `pend`=0, FSM=`S_HOLD`.
  - `vs_d1`=1, `req_d1`=0, synchronizer=0.
  - `out_hs`=1, `out_vs`=1, `out_de`=0, `out_rgb`=0.
- Reset mid-operation discards any pending step without an ack.
- Pixel latency: exactly 1 `rgb_clk` on all `out_*` signals.
- Tick to `pat_sel` change: registered on the tick cycle; visible the cycle after the vsync falling edge is sampled.
- `step_ack` is high the same cycle `pat_sel` updates.
- Latency from `step_req` edge to `step_ack`: 1 to (1 frame + 2) cycles.
- `auto_en` latency: 2 cycles through the synchronizer, then 1 cycle for the state change.

## Test plan
- Reset release with `rgb_timing` running, `auto_en`=0 → `pat_sel`=0 indefinitely; on a line with y=0, x=0/20/479 → `out_rgb` 800000/400000/000001 one cycle after `rgb_de`.
- `auto_en`=1, `FRAMES_PER_PATTERN`=3 → `pat_sel` steps 0,1,2,3,0 every 3 vsync falls; `frame_cnt` cycles 0,1,2; no `step_ack`.
- Manual mode: pulse `step_req` high for 5 cycles mid-frame → exactly one `step_ack` on the next vsync fall, `pat_sel` 0→1; req held high for 10 frames → only one advance.
- Auto mode with `frame_cnt`=2 (expiry) and `step_req` edge in the same frame → single advance, one `step_ack`, `frame_cnt`=0.
- Pattern 1 with x=0, 60, 420 → FFFFFF, FFFF00, 000000; pattern 3 with (16,0) → FFFFFF, (16,16) → 000000; `rgb_de`=0 → 000000.
- Assert `rgb_rst_n` low while `pend`=1 → all outputs at reset values asynchronously; after release no `step_ack` and `pat_sel`=0.
